// File: rtl/nx_fifo_pkg.sv
// Shared sizing and pointer helpers for the flexible flop-based FIFO.
package nx_fifo_pkg;

    // Width needed to hold a count from 0 to depth inclusive.
    function automatic int unsigned calc_cw(input int unsigned depth);
        return int'($clog2(depth + 1));
    endfunction

    // Width needed to address depth entries (at least one bit).
    function automatic int unsigned calc_pw(input int unsigned depth);
        if (depth < 2) begin
            return 1;
        end
        return int'($clog2(depth));
    endfunction

    // Pointer increment that wraps at depth-1, valid for any depth.
    function automatic int unsigned ptr_inc_wrap(input int unsigned ptr,
                                                 input int unsigned depth);
        if (ptr >= depth - 1) begin
            return 32'd0;
        end
        return ptr + 32'd1;
    endfunction

endpackage : nx_fifo_pkg

// File: rtl/nx_fifo_ctrl_flex.sv
// Control path of the flexible FIFO: pointers, occupancy, flags, watermark.
module nx_fifo_ctrl_flex
    import nx_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CW    = calc_cw(DEPTH),
    localparam int unsigned PW    = calc_pw(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          wen_i,
    input  logic          ren_i,
    input  logic          clear_i,
    input  logic [CW-1:0] af_level_i,
    input  logic [CW-1:0] ae_level_i,
    output logic          push_o,
    output logic [PW-1:0] wptr_o,
    output logic [PW-1:0] rptr_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          almost_full_o,
    output logic          almost_empty_o,
    output logic [CW-1:0] used_slots_o,
    output logic [CW-1:0] free_slots_o,
    output logic          overflow_o,
    output logic          underflow_o,
    output logic          ovf_sticky_o,
    output logic          udf_sticky_o,
    output logic [CW-1:0] hwm_o
);

    localparam logic [CW-1:0] DEPTH_CW = CW'(DEPTH);

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] hwm_q, hwm_d;
    logic          ovf_sticky_q, ovf_sticky_d;
    logic          udf_sticky_q, udf_sticky_d;

    logic empty_c, full_c;
    logic push_c, pop_c;
    logic ovf_c, udf_c;

    // Occupancy decode and request qualification; clear masks everything.
    always_comb begin
        empty_c = (count_q == '0);
        full_c  = (count_q == DEPTH_CW);
        push_c  = wen_i && !full_c  && !clear_i;
        pop_c   = ren_i && !empty_c && !clear_i;
        ovf_c   = wen_i && full_c   && !clear_i;
        udf_c   = ren_i && empty_c  && !clear_i;
    end

    // Next-state for pointers, count, watermark and sticky error flags.
    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        hwm_d        = hwm_q;
        ovf_sticky_d = ovf_sticky_q;
        udf_sticky_d = udf_sticky_q;

        if (clear_i) begin
            wptr_d       = '0;
            rptr_d       = '0;
            count_d      = '0;
            hwm_d        = '0;
            ovf_sticky_d = 1'b0;
            udf_sticky_d = 1'b0;
        end else begin
            if (push_c) begin
                wptr_d = PW'(ptr_inc_wrap(32'(wptr_q), DEPTH));
            end
            if (pop_c) begin
                rptr_d = PW'(ptr_inc_wrap(32'(rptr_q), DEPTH));
            end
            unique case ({push_c, pop_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (count_d > hwm_q) begin
                hwm_d = count_d;
            end
            ovf_sticky_d = ovf_sticky_q | ovf_c;
            udf_sticky_d = udf_sticky_q | udf_c;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            hwm_q        <= '0;
            ovf_sticky_q <= 1'b0;
            udf_sticky_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            hwm_q        <= hwm_d;
            ovf_sticky_q <= ovf_sticky_d;
            udf_sticky_q <= udf_sticky_d;
        end
    end

    // Threshold compares run against the registered count so level changes act at once.
    always_comb begin
        almost_full_o  = (count_q >= af_level_i);
        almost_empty_o = (count_q <= ae_level_i);
    end

    assign push_o       = push_c;
    assign wptr_o       = wptr_q;
    assign rptr_o       = rptr_q;
    assign empty_o      = empty_c;
    assign full_o       = full_c;
    assign used_slots_o = count_q;
    assign free_slots_o = DEPTH_CW - count_q;
    assign overflow_o   = ovf_c;
    assign underflow_o  = udf_c;
    assign ovf_sticky_o = ovf_sticky_q;
    assign udf_sticky_o = udf_sticky_q;
    assign hwm_o        = hwm_q;

endmodule : nx_fifo_ctrl_flex

// File: rtl/nx_fifo_flex.sv
// Flexible flop-based synchronous FIFO with show-ahead read and status reporting.
module nx_fifo_flex
    import nx_fifo_pkg::*;
#(
    parameter  int unsigned WIDTH = 34,
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned CW    = calc_cw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic             ren,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    input  logic [CW-1:0]    af_level,
    input  logic [CW-1:0]    ae_level,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    used_slots,
    output logic [CW-1:0]    free_slots,
    output logic             overflow,
    output logic             underflow,
    output logic             ovf_sticky,
    output logic             udf_sticky,
    output logic [CW-1:0]    hwm
);

    localparam int unsigned PW = calc_pw(DEPTH);

    logic             push_c;
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [DEPTH-1:0] we_c;
    logic [WIDTH-1:0] rd_mux_c;
    logic [WIDTH-1:0] mem_q [DEPTH];

    nx_fifo_ctrl_flex #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .wen_i          (wen),
        .ren_i          (ren),
        .clear_i        (clear),
        .af_level_i     (af_level),
        .ae_level_i     (ae_level),
        .push_o         (push_c),
        .wptr_o         (wptr),
        .rptr_o         (rptr),
        .empty_o        (empty),
        .full_o         (full),
        .almost_full_o  (almost_full),
        .almost_empty_o (almost_empty),
        .used_slots_o   (used_slots),
        .free_slots_o   (free_slots),
        .overflow_o     (overflow),
        .underflow_o    (underflow),
        .ovf_sticky_o   (ovf_sticky),
        .udf_sticky_o   (udf_sticky),
        .hwm_o          (hwm)
    );

    // One-hot write-enable decode of the write pointer.
    always_comb begin
        we_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            we_c[i] = push_c && (wptr == PW'(i));
        end
    end

    // Storage array; no reset because contents are masked while empty.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (we_c[i]) begin
                mem_q[i] <= wdata;
            end
        end
    end

    // Show-ahead read mux gated to zero when empty.
    always_comb begin
        rd_mux_c = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rptr == PW'(i)) begin
                rd_mux_c = mem_q[i];
            end
        end
        rdata = empty ? '0 : rd_mux_c;
    end

endmodule : nx_fifo_flex

// File: tb/tb_nx_fifo_flex.sv
// Self-checking bench for nx_fifo_flex with a queue-based reference model.
module tb_nx_fifo_flex;

    localparam int unsigned W  = 34;
    localparam int unsigned D  = 5;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          rst_n, wen, ren, clear;
    logic [W-1:0]  wdata;
    logic [CW-1:0] af_level, ae_level;
    logic [W-1:0]  rdata;
    logic          empty, full, almost_full, almost_empty;
    logic [CW-1:0] used_slots, free_slots, hwm;
    logic          overflow, underflow, ovf_sticky, udf_sticky;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mq[$];
    int           m_hwm;
    bit           m_ovs, m_uds;
    logic         got_ovf, got_udf;
    bit           exp_ovf, exp_udf;

    always #5 clk = ~clk;

    nx_fifo_flex #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .ren(ren), .clear(clear),
        .wdata(wdata), .af_level(af_level), .ae_level(ae_level),
        .rdata(rdata), .empty(empty), .full(full),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .used_slots(used_slots), .free_slots(free_slots),
        .overflow(overflow), .underflow(underflow),
        .ovf_sticky(ovf_sticky), .udf_sticky(udf_sticky), .hwm(hwm)
    );

    function automatic logic [W-1:0] head();
        return (mq.size() == 0) ? '0 : mq[0];
    endfunction

    function automatic logic [W-1:0] rnd_word();
        return {2'($urandom), 32'($urandom)};
    endfunction

    // One clock of stimulus; captures pre-edge error pulses and advances the model.
    task automatic step(input bit w, input bit r, input bit c, input logic [W-1:0] d);
        bit was_full, was_empty;
        wen = w; ren = r; clear = c; wdata = d;
        #1;
        got_ovf   = overflow;
        got_udf   = underflow;
        was_full  = (mq.size() == D);
        was_empty = (mq.size() == 0);
        exp_ovf   = w && !c && was_full;
        exp_udf   = r && !c && was_empty;
        @(posedge clk);
        if (c) begin
            mq.delete(); m_hwm = 0; m_ovs = 0; m_uds = 0;
        end else begin
            if (r && !was_empty) void'(mq.pop_front());
            if (w && !was_full) mq.push_back(d);
            if (mq.size() > m_hwm) m_hwm = mq.size();
            m_ovs = m_ovs | exp_ovf;
            m_uds = m_uds | exp_udf;
        end
        #1;
        wen = 1'b0; ren = 1'b0; clear = 1'b0;
    endtask

    task automatic do_reset(input bit w, input bit r);
        rst_n = 1'b0; wen = w; ren = r; wdata = rnd_word();
        @(posedge clk);
        mq.delete(); m_hwm = 0; m_ovs = 0; m_uds = 0;
        #1;
        rst_n = 1'b1; wen = 1'b0; ren = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        af_level = 3'd4; ae_level = 3'd1;
        do_reset(1'b1, 1'b1);
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%0d want=1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%0d want=0", full); end
        total++; if (used_slots !== 3'd0) begin bad++; $display("FAIL reset_used got=%0d want=0", used_slots); end
        total++; if (free_slots !== 3'd5) begin bad++; $display("FAIL reset_free got=%0d want=5", free_slots); end
        total++; if (rdata !== '0) begin bad++; $display("FAIL reset_rdata got=%h want=0", rdata); end
        total++; if (hwm !== 3'd0) begin bad++; $display("FAIL reset_hwm got=%0d want=0", hwm); end
        total++; if ({ovf_sticky, udf_sticky} !== 2'b00) begin bad++; $display("FAIL reset_sticky got=%b want=00", {ovf_sticky, udf_sticky}); end
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%0d want=1", almost_empty); end
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL reset_af got=%0d want=0", almost_full); end
    endtask

    task automatic test_fill();
        do_reset(1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b0, 1'b0, W'(i));
            total++; if (used_slots !== 3'(i)) begin bad++; $display("FAIL fill_used i=%0d got=%0d want=%0d", i, used_slots, i); end
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got=%0d want=1", full); end
        step(1'b1, 1'b0, 1'b0, W'(6));
        total++; if (got_ovf !== 1'b1) begin bad++; $display("FAIL fill_ovf got=%0d want=1", got_ovf); end
        total++; if (ovf_sticky !== 1'b1) begin bad++; $display("FAIL fill_ovf_sticky got=%0d want=1", ovf_sticky); end
        total++; if (hwm !== 3'd5) begin bad++; $display("FAIL fill_hwm got=%0d want=5", hwm); end
        step(1'b0, 1'b0, 1'b0, '0);
        total++; if (got_ovf !== 1'b0) begin bad++; $display("FAIL fill_ovf_single got=%0d want=0", got_ovf); end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 5; i++) begin
            total++; if (rdata !== W'(i)) begin bad++; $display("FAIL drain_rdata i=%0d got=%h want=%h", i, rdata, W'(i)); end
            step(1'b0, 1'b1, 1'b0, '0);
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%0d want=1", empty); end
        total++; if (rdata !== '0) begin bad++; $display("FAIL drain_rdata_zero got=%h want=0", rdata); end
        step(1'b0, 1'b1, 1'b0, '0);
        total++; if (got_udf !== 1'b1) begin bad++; $display("FAIL drain_udf got=%0d want=1", got_udf); end
        total++; if (udf_sticky !== 1'b1) begin bad++; $display("FAIL drain_udf_sticky got=%0d want=1", udf_sticky); end
    endtask

    task automatic test_wrap();
        do_reset(1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, rnd_word());
        step(1'b1, 1'b0, 1'b0, rnd_word());
        for (int i = 0; i < 13; i++) begin
            total++; if (rdata !== head()) begin bad++; $display("FAIL wrap_rdata i=%0d got=%h want=%h", i, rdata, head()); end
            step(1'b1, 1'b1, 1'b0, rnd_word());
            total++; if (used_slots !== 3'd2) begin bad++; $display("FAIL wrap_used i=%0d got=%0d want=2", i, used_slots); end
        end
        for (int i = 0; i < 2; i++) begin
            total++; if (rdata !== head()) begin bad++; $display("FAIL wrap_tail i=%0d got=%h want=%h", i, rdata, head()); end
            step(1'b0, 1'b1, 1'b0, '0);
        end
    endtask

    task automatic test_simultaneous();
        do_reset(1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, W'(34'h2_0000_00AA));
        total++; if (got_udf !== 1'b1) begin bad++; $display("FAIL simul_empty_udf got=%0d want=1", got_udf); end
        total++; if (used_slots !== 3'd1) begin bad++; $display("FAIL simul_empty_used got=%0d want=1", used_slots); end
        total++; if (rdata !== 34'h2_0000_00AA) begin bad++; $display("FAIL simul_empty_rdata got=%h want=2000000aa", rdata); end
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, rnd_word());
        step(1'b1, 1'b1, 1'b0, rnd_word());
        total++; if (got_ovf !== 1'b1) begin bad++; $display("FAIL simul_full_ovf got=%0d want=1", got_ovf); end
        total++; if (used_slots !== 3'd4) begin bad++; $display("FAIL simul_full_used got=%0d want=4", used_slots); end
        total++; if (rdata !== head()) begin bad++; $display("FAIL simul_full_rdata got=%h want=%h", rdata, head()); end
    endtask

    task automatic test_clear();
        do_reset(1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, rnd_word());
        total++; if (udf_sticky !== 1'b1) begin bad++; $display("FAIL clear_pre_sticky got=%0d want=1", udf_sticky); end
        step(1'b1, 1'b1, 1'b1, rnd_word());
        total++; if ({got_ovf, got_udf} !== 2'b00) begin bad++; $display("FAIL clear_pulses got=%b want=00", {got_ovf, got_udf}); end
        total++; if (used_slots !== 3'd0) begin bad++; $display("FAIL clear_used got=%0d want=0", used_slots); end
        total++; if (hwm !== 3'd0) begin bad++; $display("FAIL clear_hwm got=%0d want=0", hwm); end
        total++; if ({ovf_sticky, udf_sticky} !== 2'b00) begin bad++; $display("FAIL clear_sticky got=%b want=00", {ovf_sticky, udf_sticky}); end
        total++; if (rdata !== '0) begin bad++; $display("FAIL clear_rdata got=%h want=0", rdata); end
    endtask

    task automatic test_thresholds();
        af_level = 3'd4; ae_level = 3'd1;
        do_reset(1'b0, 1'b0);
        total++; if (almost_empty !== 1'b1) begin bad++; $display("FAIL thr_ae0 got=%0d want=1", almost_empty); end
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 1'b0, 1'b0, rnd_word());
            total++; if (almost_full !== (i >= 4)) begin bad++; $display("FAIL thr_af occ=%0d got=%0d want=%0d", i, almost_full, (i >= 4)); end
            total++; if (almost_empty !== (i <= 1)) begin bad++; $display("FAIL thr_ae occ=%0d got=%0d want=%0d", i, almost_empty, (i <= 1)); end
        end
        af_level = 3'd6; #1;
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL thr_af_above_depth got=%0d want=0", almost_full); end
        step(1'b1, 1'b0, 1'b0, rnd_word());
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL thr_af_above_full got=%0d want=0", almost_full); end
        af_level = 3'd0; #1;
        total++; if (almost_full !== 1'b1) begin bad++; $display("FAIL thr_af_zero got=%0d want=1", almost_full); end
        af_level = 3'd4;
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, '0);
        total++; if (used_slots !== 3'd3) begin bad++; $display("FAIL thr_occ3 got=%0d want=3", used_slots); end
        do_reset(1'b1, 1'b1);
        total++; if ({empty, full, used_slots, free_slots} !== {1'b1, 1'b0, 3'd0, 3'd5}) begin bad++; $display("FAIL thr_reset_status got=%b/%b/%0d/%0d want=1/0/0/5", empty, full, used_slots, free_slots); end
        total++; if ({rdata, hwm} !== {34'd0, 3'd0}) begin bad++; $display("FAIL thr_reset_data got=%h/%0d want=0/0", rdata, hwm); end
        total++; if ({almost_empty, almost_full} !== 2'b10) begin bad++; $display("FAIL thr_reset_levels got=%b want=10", {almost_empty, almost_full}); end
    endtask

    task automatic test_random();
        do_reset(1'b0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            bit w, r, c;
            if ($urandom_range(0, 15) == 0) begin
                af_level = 3'($urandom_range(0, 7));
                ae_level = 3'($urandom_range(0, 7));
            end
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            c = ($urandom_range(0, 99) < 3);
            step(w, r, c, rnd_word());
            total++; if (got_ovf !== exp_ovf) begin bad++; $display("FAIL rnd_ovf n=%0d got=%0d want=%0d", n, got_ovf, exp_ovf); end
            total++; if (got_udf !== exp_udf) begin bad++; $display("FAIL rnd_udf n=%0d got=%0d want=%0d", n, got_udf, exp_udf); end
            total++; if (rdata !== head()) begin bad++; $display("FAIL rnd_rdata n=%0d got=%h want=%h", n, rdata, head()); end
            total++; if (used_slots !== 3'(mq.size())) begin bad++; $display("FAIL rnd_used n=%0d got=%0d want=%0d", n, used_slots, mq.size()); end
            total++; if (free_slots !== 3'(D - mq.size())) begin bad++; $display("FAIL rnd_free n=%0d got=%0d want=%0d", n, free_slots, D - mq.size()); end
            total++; if (empty !== (mq.size() == 0)) begin bad++; $display("FAIL rnd_empty n=%0d got=%0d", n, empty); end
            total++; if (full !== (mq.size() == D)) begin bad++; $display("FAIL rnd_full n=%0d got=%0d", n, full); end
            total++; if (almost_full !== (mq.size() >= int'(af_level))) begin bad++; $display("FAIL rnd_af n=%0d got=%0d lvl=%0d occ=%0d", n, almost_full, af_level, mq.size()); end
            total++; if (almost_empty !== (mq.size() <= int'(ae_level))) begin bad++; $display("FAIL rnd_ae n=%0d got=%0d lvl=%0d occ=%0d", n, almost_empty, ae_level, mq.size()); end
            total++; if (hwm !== 3'(m_hwm)) begin bad++; $display("FAIL rnd_hwm n=%0d got=%0d want=%0d", n, hwm, m_hwm); end
            total++; if ({ovf_sticky, udf_sticky} !== {m_ovs, m_uds}) begin bad++; $display("FAIL rnd_sticky n=%0d got=%b want=%b", n, {ovf_sticky, udf_sticky}, {m_ovs, m_uds}); end
        end
    endtask

    initial begin
        rst_n = 1'b0; wen = 1'b0; ren = 1'b0; clear = 1'b0; wdata = '0;
        af_level = 3'd4; ae_level = 3'd1;
        @(posedge clk); #1;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_clear();
        test_thresholds();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_nx_fifo_flex

// File: doc/nx_fifo_flex.md
# nx_fifo_flex

Parametrised flop-based synchronous FIFO and the successor to the fixed two-entry 34-bit FIFO. It adds:
- arbitrary width and depth, including depths that are not a power of two;
- runtime-programmable almost-full and almost-empty levels;
- sticky error flags;
- a high-watermark occupancy register.

It sits between datapath producers and consumers inside one clock domain and keeps the show-ahead read interface, so existing FIFO users port over unchanged.

## Interface
- `WIDTH`, 34, data width in bits, ≥1
- `DEPTH`, 8, number of entries, ≥2, any integer
- `CW`, $clog2(DEPTH+1), derived, width of count-type signals; not overridable
- `clk` input 1: sole clock, rising edge
- `rst_n` input 1: reset; one clock, synchronous, active-low
- `wen` input 1: push request
- `ren` input 1: pop request
- `clear` input 1: synchronous flush
- `wdata` input WIDTH: push data
- `af_level` input CW: almost-full threshold
- `ae_level` input CW: almost-empty threshold
- `rdata` output WIDTH: head entry (show-ahead); zero when empty
- `empty` output 1: no entries
- `full` output 1: DEPTH entries
- `almost_full` output 1: used_slots ≥ af_level
- `almost_empty` output 1: used_slots ≤ ae_level
- `used_slots` output CW: occupancy
- `free_slots` output CW: DEPTH − used_slots
- `overflow` output 1: push rejected this cycle
- `underflow` output 1: pop rejected this cycle
- `ovf_sticky` output 1: an overflow has occurred since reset/clear
- `udf_sticky` output 1: an underflow has occurred since reset/clear
- `hwm` output CW: peak used_slots since reset/clear

## Operation
- **Pointers.** Write and read pointers each cover 0..DEPTH−1 and wrap from DEPTH−1 to 0. Occupancy is an explicit counter, not pointer difference.
- **Push accept.** A push is accepted when `wen && !full && !clear`. `wdata` is written to `mem[wptr]` and wptr advances.
- **Pop accept.** A pop is accepted when `ren && !empty && !clear`. rptr advances.
- **Push rejection.** `full` blocks a push even when a pop is accepted in the same cycle; no write-through when full.
- **Simultaneous push and pop.** When empty, the push is accepted, the pop is rejected, and `underflow` asserts. Otherwise both are accepted and the count is unchanged.
- **Error flags.**
  - `overflow = wen && full && !clear`.
  - `underflow = ren && empty && !clear`.
  - Both are combinational, single-cycle, and have no effect on state.
- **Sticky flags.** `ovf_sticky` and `udf_sticky` set on the cycle after the corresponding pulse. They clear only on reset or `clear`.
- **Clear.**
  - Pointers, count, `hwm` and sticky flags return to 0.
  - Clear has priority over `wen` and `ren` in the same cycle; both are ignored and no flags pulse.
  - Storage contents are untouched.
- **High watermark.** `hwm` is updated to the next count whenever the next count exceeds the current `hwm`.
- **Read data.** `rdata = empty ? 0 : mem[rptr]`.
- **Thresholds.**
  - `af_level` and `ae_level` are compared combinationally against registered `used_slots`; level changes take effect immediately.
  - `af_level = 0` forces `almost_full` high.
  - `af_level > DEPTH` keeps `almost_full` low.
- **Reset values** (`rst_n` low at a clock edge):
  - `empty` = 1, `almost_empty` = 1 when `ae_level` ≥ 0.
  - `full` = 0, `used_slots` = 0, `free_slots` = DEPTH.
  - `rdata` = 0, `hwm` = 0, sticky flags = 0, `overflow`/`underflow` follow their equations.
- **Storage reset.** Storage flops have no reset; their contents are never visible while `empty`.

## Timing
- **Push to read.** A push accepted at edge N gives `empty` = 0 and valid `rdata` from N+1. Latency is 1 cycle; there is no output register.
- **Pop.** A pop accepted at edge N presents the next entry, or `rdata` = 0 if the FIFO is now empty, from N+1.
- **Status update.** `full`, `used_slots`, `free_slots`, `hwm` and the sticky flags are registered and update on the edge after the causing event.
- **Reset mid-operation.** Reset takes effect at the next edge regardless of `wen`/`ren`/`clear`; requests in that cycle are dropped.
- **Back-to-back operation.** Sustained throughput is 1 push + 1 pop per cycle when neither full nor empty.

## Structure
- **Package `nx_fifo_pkg`.** Holds the CW computation function and a shared pointer-increment-with-wrap function for non-power-of-two depths.
- **Sub-module `nx_fifo_ctrl_flex`.** Contains pointers, count, flags, hwm and thresholds; parametrised by DEPTH; no data. The top level holds the WIDTH×DEPTH storage, write-enable decode and read mux with empty gating.

## Test plan
All scenarios use `WIDTH` = 34, `DEPTH` = 5.
- **Fill.** Push 5 words 0x1..0x5 → `full` = 1 and `used_slots` = 5 after the 5th edge. A 6th push gives `overflow` = 1 for one cycle, then `ovf_sticky` = 1 and `hwm` = 5.
- **Drain and underflow.** Pop 5 → `rdata` sequence 0x1..0x5, then `empty` = 1 and `rdata` = 0. A further pop gives `underflow` = 1.
- **Wrap-around.** Run 13 push/pop pairs interleaved at occupancy 2 → data order preserved across the 4→0 wrap and `used_slots` stays 2.
- **Simultaneous events.**
  - Push+pop when empty: push accepted, `underflow` = 1.
  - Push+pop when full: pop accepted, push rejected, `overflow` = 1, `used_slots` = 4.
- **Clear.** Assert `clear` with `wen` = `ren` = 1 at occupancy 3 → next cycle `used_slots` = 0, `hwm` = 0, sticky flags = 0, no error pulses.
- **Thresholds and reset.** With `af_level` = 4 and `ae_level` = 1: `almost_full` rises on the 4th push, and `almost_empty` is high at occupancy 0 and 1. Reset asserted at occupancy 3 → all outputs at their reset values next cycle.
